// File: rtl/proc_pkg.sv
// Shared processor definitions: phase strobe patterns, checker states and error codes.
// Imported by the phase-sequence checker and its neighbours.
package proc_pkg;

    localparam logic [3:0] PH_F    = 4'b1000;
    localparam logic [3:0] PH_D    = 4'b0100;
    localparam logic [3:0] PH_E    = 4'b0010;
    localparam logic [3:0] PH_I    = 4'b0001;
    localparam logic [3:0] PH_NONE = 4'b0000;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_EXP_F = 3'd1,
        ST_EXP_D = 3'd2,
        ST_EXP_E = 3'd3,
        ST_EXP_I = 3'd4
    } chk_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MULTI = 2'b01;
    localparam logic [1:0] ERR_ORDER = 2'b10;
    localparam logic [1:0] ERR_DROP  = 2'b11;

    // WAIT waits for a fetch, so it expects the same strobe as EXP_F.
    function automatic logic [3:0] exp_phase(input chk_state_e s);
        logic [3:0] ph;
        case (s)
            ST_WAIT:  ph = PH_F;
            ST_EXP_F: ph = PH_F;
            ST_EXP_D: ph = PH_D;
            ST_EXP_E: ph = PH_E;
            ST_EXP_I: ph = PH_I;
            default:  ph = PH_F;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count up on inc, holding at all-ones.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_chk.sv
// Receiving-end checker for the one-hot F/D/E/I phase strobes: tracks the expected
// phase, classifies illegal patterns and counts completed instruction cycles.
module seq_chk
    import proc_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             f,
    input  logic             d,
    input  logic             e,
    input  logic             i,
    input  logic             err_clr,
    output logic             running,
    output logic [3:0]       phase_exp,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [3:0]       p_s;
    logic [3:0]       expected_s;
    chk_state_e       state_r;
    chk_state_e       state_nx_s;
    logic             err_s;
    logic [1:0]       code_s;
    logic             inc_s;
    logic             running_r;
    logic [3:0]       phase_exp_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [CNT_W-1:0] instr_cnt_r;

    assign p_s = {f, d, e, i};

    // State register plus the outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r     <= ST_WAIT;
            running_r   <= 1'b0;
            phase_exp_r <= PH_F;
        end else begin
            state_r     <= state_nx_s;
            running_r   <= (state_nx_s != ST_WAIT);
            phase_exp_r <= exp_phase(state_nx_s);
        end
    end

    // Next-state and error classification; X/Z or multi-hot strobes fall to default.
    always_comb begin
        state_nx_s = state_r;
        err_s      = 1'b0;
        code_s     = ERR_NONE;
        inc_s      = 1'b0;
        expected_s = exp_phase(state_r);
        case (p_s)
            PH_NONE: begin
                if (state_r == ST_WAIT) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_WAIT;
                    err_s      = 1'b1;
                    code_s     = ERR_DROP;
                end
            end
            PH_F, PH_D, PH_E, PH_I: begin
                if (p_s == expected_s) begin
                    case (state_r)
                        ST_WAIT:  state_nx_s = ST_EXP_D;
                        ST_EXP_F: state_nx_s = ST_EXP_D;
                        ST_EXP_D: state_nx_s = ST_EXP_E;
                        ST_EXP_E: state_nx_s = ST_EXP_I;
                        ST_EXP_I: begin
                            state_nx_s = ST_EXP_F;
                            inc_s      = 1'b1;
                        end
                        default:  state_nx_s = ST_WAIT;
                    endcase
                end else begin
                    // A stray F also resyncs through WAIT; only the next F re-locks.
                    state_nx_s = ST_WAIT;
                    err_s      = 1'b1;
                    code_s     = ERR_ORDER;
                end
            end
            default: begin
                state_nx_s = ST_WAIT;
                err_s      = 1'b1;
                code_s     = ERR_MULTI;
            end
        endcase
    end

    // Sticky error flag; the first code since the last clear is kept, a same-cycle error beats err_clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (err_s) begin
            err_r <= 1'b1;
            if (!err_r || err_clr) begin
                err_code_r <= code_s;
            end else begin
                err_code_r <= err_code_r;
            end
        end else if (err_clr) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            err_r      <= err_r;
            err_code_r <= err_code_r;
        end
    end

    // Completed-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (inc_s) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .clr (clr),
        .inc (err_s),
        .cnt (err_cnt)
    );

    assign running   = running_r;
    assign phase_exp = phase_exp_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_seq_chk.sv
// Self-checking bench for seq_chk: a default-width instance and a narrow
// (CNT_W=2, ERR_W=2) instance share stimulus and are checked against a reference model.
module tb_seq_chk;

    logic clk;
    logic clr;
    logic f, d, e, i;
    logic err_clr;

    logic       running0, err0;
    logic [3:0] phase0;
    logic [1:0] code0;
    logic [3:0] errcnt0;
    logic [7:0] instr0;

    logic       running1, err1;
    logic [3:0] phase1;
    logic [1:0] code1;
    logic [1:0] errcnt1;
    logic [1:0] instr1;

    int tests;
    int fails;

    typedef struct {
        logic       run;
        logic [3:0] ph;
        logic       er;
        logic [1:0] code;
        int         errn;
        int         instr;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic       m_lock;
    logic [3:0] m_exp;
    logic       m_err;
    logic [1:0] m_code;
    int         m_errn;
    int         m_instr;

    seq_chk u0 (
        .clk(clk), .clr(clr), .f(f), .d(d), .e(e), .i(i), .err_clr(err_clr),
        .running(running0), .phase_exp(phase0), .err(err0), .err_code(code0),
        .err_cnt(errcnt0), .instr_cnt(instr0)
    );

    seq_chk #(.CNT_W(2), .ERR_W(2)) u1 (
        .clk(clk), .clr(clr), .f(f), .d(d), .e(e), .i(i), .err_clr(err_clr),
        .running(running1), .phase_exp(phase1), .err(err1), .err_code(code1),
        .err_cnt(errcnt1), .instr_cnt(instr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_lock  = 1'b0;
        m_exp   = 4'b1000;
        m_err   = 1'b0;
        m_code  = 2'b00;
        m_errn  = 0;
        m_instr = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic ec);
        int         pc;
        logic       bad;
        logic [1:0] c;
        pc  = $countones(p);
        bad = 1'b1;
        c   = 2'b00;
        if (!m_lock && pc == 0) bad = 1'b0;
        else if (pc > 1) c = 2'b01;
        else if (pc == 0) c = 2'b11;
        else if (p != m_exp) c = 2'b10;
        else bad = 1'b0;
        if (bad) begin
            if (!m_err || ec) m_code = c;
            m_err  = 1'b1;
            m_errn = m_errn + 1;
            m_lock = 1'b0;
            m_exp  = 4'b1000;
        end else begin
            if (pc == 1) begin
                if (p == 4'b0001) m_instr = m_instr + 1;
                m_lock = 1'b1;
                m_exp  = {p[0], p[3:1]};
            end
            if (ec) begin
                m_err  = 1'b0;
                m_code = 2'b00;
            end
        end
    endtask

    // One clock of stimulus: push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic [3:0] p, input logic ec);
        exp_t x;
        @(negedge clk);
        {f, d, e, i} = p;
        err_clr      = ec;
        model_step(p, ec);
        x.run = m_lock; x.ph = m_exp; x.er = m_err; x.code = m_code;
        x.errn = m_errn; x.instr = m_instr;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        tests++; if (running0 !== x.run) begin fails++; $display("FAIL running0: got %0b want %0b p=%b", running0, x.run, p); end
        tests++; if (phase0 !== x.ph) begin fails++; $display("FAIL phase_exp0: got %b want %b p=%b", phase0, x.ph, p); end
        tests++; if (err0 !== x.er) begin fails++; $display("FAIL err0: got %0b want %0b p=%b", err0, x.er, p); end
        tests++; if (code0 !== x.code) begin fails++; $display("FAIL err_code0: got %b want %b p=%b", code0, x.code, p); end
        tests++; if (errcnt0 !== 4'((x.errn > 15) ? 15 : x.errn)) begin fails++; $display("FAIL err_cnt0: got %0d want %0d", errcnt0, (x.errn > 15) ? 15 : x.errn); end
        tests++; if (instr0 !== 8'(x.instr)) begin fails++; $display("FAIL instr_cnt0: got %0d want %0d", instr0, x.instr % 256); end
        tests++; if (running1 !== x.run || phase1 !== x.ph || err1 !== x.er || code1 !== x.code) begin fails++; $display("FAIL status1: got %0b/%b/%0b/%b want %0b/%b/%0b/%b", running1, phase1, err1, code1, x.run, x.ph, x.er, x.code); end
        tests++; if (errcnt1 !== 2'((x.errn > 3) ? 3 : x.errn)) begin fails++; $display("FAIL err_cnt1: got %0d want %0d", errcnt1, (x.errn > 3) ? 3 : x.errn); end
        tests++; if (instr1 !== 2'(x.instr)) begin fails++; $display("FAIL instr_cnt1: got %0d want %0d", instr1, x.instr % 4); end
    endtask

    task automatic test_reset();
        clr = 1'b1; {f, d, e, i} = 4'b0000; err_clr = 1'b0;
        #2 clr = 1'b0;
        #1;
        model_reset();
        tests++; if (running0 !== 1'b0 || err0 !== 1'b0 || code0 !== 2'b00) begin fails++; $display("FAIL reset_flags: got run=%0b err=%0b code=%b", running0, err0, code0); end
        tests++; if (phase0 !== 4'b1000) begin fails++; $display("FAIL reset_phase: got %b want 1000", phase0); end
        tests++; if (errcnt0 !== 4'd0 || instr0 !== 8'd0) begin fails++; $display("FAIL reset_cnts: got err_cnt=%0d instr=%0d want 0/0", errcnt0, instr0); end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_lock();
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
        tests++; if (running0 !== 1'b0) begin fails++; $display("FAIL idle_running: got %0b want 0", running0); end
        step(4'b1000, 1'b0);
        tests++; if (running0 !== 1'b1) begin fails++; $display("FAIL lock_running: got %0b want 1", running0); end
        step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(4'b1000, 1'b0); step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
        end
        tests++; if (instr0 !== 8'd3 || err0 !== 1'b0) begin fails++; $display("FAIL lock_instr: got instr=%0d err=%0b want 3/0", instr0, err0); end
    endtask

    task automatic test_multi();
        step(4'b1000, 1'b0);
        step(4'b1100, 1'b0);
        tests++; if (err0 !== 1'b1 || code0 !== 2'b01 || errcnt0 !== 4'd1) begin fails++; $display("FAIL multi: got err=%0b code=%b cnt=%0d want 1/01/1", err0, code0, errcnt0); end
        tests++; if (running0 !== 1'b0 || phase0 !== 4'b1000) begin fails++; $display("FAIL multi_resync: got run=%0b ph=%b want 0/1000", running0, phase0); end
    endtask

    task automatic test_order();
        step(4'b1000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        tests++; if (code0 !== 2'b10 || err0 !== 1'b1) begin fails++; $display("FAIL order: got code=%b err=%0b want 10/1", code0, err0); end
        step(4'b0000, 1'b0);
        tests++; if (errcnt0 !== 4'd2) begin fails++; $display("FAIL wait_idle: got err_cnt=%0d want 2", errcnt0); end
        step(4'b1000, 1'b0);
        tests++; if (running0 !== 1'b1) begin fails++; $display("FAIL relock: got running=%0b want 1", running0); end
    endtask

    task automatic test_drop();
        step(4'b0100, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        tests++; if (code0 !== 2'b11) begin fails++; $display("FAIL drop: got code=%b want 11", code0); end
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        tests++; if (code0 !== 2'b11 || errcnt0 !== 4'd4) begin fails++; $display("FAIL first_wins: got code=%b cnt=%0d want 11/4", code0, errcnt0); end
    endtask

    task automatic test_clr_same();
        step(4'b1000, 1'b0);
        step(4'b1100, 1'b1);
        tests++; if (err0 !== 1'b1 || code0 !== 2'b01) begin fails++; $display("FAIL clr_vs_err: got err=%0b code=%b want 1/01", err0, code0); end
        tests++; if (errcnt1 !== 2'd3) begin fails++; $display("FAIL sat_w2: got %0d want 3", errcnt1); end
        step(4'b1000, 1'b1);
        step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
        tests++; if (err0 !== 1'b0 || code0 !== 2'b00 || errcnt0 !== 4'd5) begin fails++; $display("FAIL clean_clr: got err=%0b code=%b cnt=%0d want 0/00/5", err0, code0, errcnt0); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 12; k++) step(4'b1100, 1'b0);
        tests++; if (errcnt0 !== 4'd15 || errcnt1 !== 2'd3) begin fails++; $display("FAIL saturate: got %0d/%0d want 15/3", errcnt0, errcnt1); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            step(4'b1000, 1'b0); step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
        end
        tests++; if (instr1 !== 2'd1 || instr0 !== 8'd9) begin fails++; $display("FAIL wrap: got %0d/%0d want 1/9", instr1, instr0); end
    endtask

    task automatic test_async_reset();
        step(4'b1000, 1'b0);
        step(4'b0100, 1'b0);
        #2;
        clr = 1'b0;
        {f, d, e, i} = 4'b0000;
        #1;
        model_reset();
        tests++; if (running0 !== 1'b0 || phase0 !== 4'b1000 || err0 !== 1'b0 || code0 !== 2'b00) begin fails++; $display("FAIL async_flags: got run=%0b ph=%b err=%0b code=%b", running0, phase0, err0, code0); end
        tests++; if (errcnt0 !== 4'd0 || instr0 !== 8'd0 || errcnt1 !== 2'd0 || instr1 !== 2'd0) begin fails++; $display("FAIL async_cnts: got %0d/%0d/%0d/%0d want 0", errcnt0, instr0, errcnt1, instr1); end
        @(negedge clk);
        clr = 1'b1;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        tests++; if (running0 !== 1'b0 || err0 !== 1'b0) begin fails++; $display("FAIL post_reset_wait: got run=%0b err=%0b want 0/0", running0, err0); end
        step(4'b1000, 1'b0);
        tests++; if (running0 !== 1'b1 || phase0 !== 4'b0100) begin fails++; $display("FAIL post_reset_lock: got run=%0b ph=%b want 1/0100", running0, phase0); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        test_reset();
        test_lock();
        test_multi();
        test_order();
        test_drop();
        test_clr_same();
        test_saturate();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
